// File: rtl/bus_bridge_mux.sv
// Master-to-NSLV bus bridge: windowed address decode, registered req/ack handshake, error
// response for unmapped addresses. Optional wait-state timeout under `BRIDGE_TIMEOUT_EN`.
module bus_bridge_mux #(
  parameter int unsigned          NSLV = 2,
  parameter int unsigned          DW   = 32,
  parameter logic [NSLV*32-1:0]   BASE = {32'h0000_7F00, 32'h0000_0000},
  parameter logic [NSLV*32-1:0]   MASK = {32'hFFFF_FF00, 32'hFFFF_C000},
  parameter int unsigned          TMO  = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 m_req,
  input  logic [31:0]          m_addr,
  input  logic [DW-1:0]        m_wdata,
  input  logic                 m_we,
  input  logic [DW/8-1:0]      m_be,
  output logic                 m_busy,
  output logic                 m_ready,
  output logic                 m_err,
  output logic [DW-1:0]        m_rdata,
  output logic [NSLV-1:0]      s_sel,
  output logic [31:0]          s_addr,
  output logic [DW-1:0]        s_wdata,
  output logic [NSLV-1:0]      s_we,
  output logic [DW/8-1:0]      s_be,
  input  logic [NSLV-1:0]      s_ack,
  input  logic [NSLV*DW-1:0]   s_rdata
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StErr} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [BW-1:0]     be_q, be_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NSLV-1:0]   hit_vec;
  logic [NSLV-1:0]   hit_oh;
  logic              ack_sel;
  logic [DW-1:0]     rdata_mux;
  logic              tmo_hit;

  // Lowest-index window wins on overlap: isolate the least significant set bit.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NSLV; i++) begin
      hit_vec[i] = ((m_addr & MASK[i*32 +: 32]) == BASE[i*32 +: 32]);
    end
    hit_oh = hit_vec & (~hit_vec + NSLV'(1));
  end

  // Only the selected slave's ack and data are observed.
  always_comb begin
    ack_sel   = |(s_ack & sel_q);
    rdata_mux = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        rdata_mux = rdata_mux | s_rdata[i*DW +: DW];
      end
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Fires in the ACCESS cycle whose un-acked increment would reach TMO; ack takes priority.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StAccess && !ack_sel) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end
    tmo_hit = (state_q == StAccess) && !ack_sel && (tmo_cnt_q == CW'(TMO - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (m_req) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          we_d    = m_we;
          be_d    = m_be;
          if (|hit_vec) begin
            sel_d   = hit_oh;
            state_d = StAccess;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end
      StAccess: begin
        if (ack_sel) begin
          rdata_d = we_q ? '0 : rdata_mux;
          sel_d   = '0;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (tmo_hit) begin
          rdata_d = '0;
          sel_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    m_busy  = (state_q != StIdle);
    m_ready = (state_q == StResp) || (state_q == StErr);
    m_err   = m_ready && err_q;
    m_rdata = rdata_q;
    s_sel   = sel_q;
    s_addr  = addr_q;
    s_wdata = wdata_q;
    s_we    = sel_q & {NSLV{we_q}};
    s_be    = be_q;
  end

endmodule

// File: tb/tb_bus_bridge_mux.sv
// Directed self-checking bench for bus_bridge_mux (default parameters, NSLV = 2, DW = 32).
module tb_bus_bridge_mux;

  logic        clk;
  logic        reset_n;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  logic        m_busy;
  logic        m_ready;
  logic        m_err;
  logic [31:0] m_rdata;
  logic [1:0]  s_sel;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [1:0]  s_we;
  logic [3:0]  s_be;
  logic [1:0]  s_ack;
  logic [63:0] s_rdata;

  int n_run;
  int n_fail;

  logic [31:0] dec_addr [8];
  logic [1:0]  dec_sel  [8];

  bus_bridge_mux dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_busy  (m_busy),
    .m_ready (m_ready),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .s_sel   (s_sel),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_we    (s_we),
    .s_be    (s_be),
    .s_ack   (s_ack),
    .s_rdata (s_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    n_run++;
    if ({m_busy, m_ready, m_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {m_busy, m_ready, m_err});
    end
    n_run++;
    if ({s_sel, s_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_sel_we: got %b want 0000", {s_sel, s_we});
    end
    n_run++;
    if ({m_rdata, s_addr, s_wdata, s_be} !== 100'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {m_rdata, s_addr, s_wdata, s_be});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read_s0();
    m_addr  = 32'h0000_0010;
    m_we    = 1'b0;
    m_be    = 4'hF;
    s_rdata = {32'h5555_5555, 32'hDEAD_BEEF};
    m_req   = 1'b1;
    tick();
    m_req = 1'b0;
    n_run++;
    if ({s_sel, s_we} !== 4'b0100) begin
      n_fail++;
      $display("FAIL rd0_sel_we: got %b want 0100", {s_sel, s_we});
    end
    n_run++;
    if (s_addr !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL rd0_s_addr: got %h want 00000010", s_addr);
    end
    n_run++;
    if ({m_busy, m_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rd0_busy_ready: got %b want 10", {m_busy, m_ready});
    end
    s_ack = 2'b01;
    tick();
    s_ack = 2'b00;
    n_run++;
    if ({m_ready, m_err, s_sel} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rd0_resp: got %b want 1000", {m_ready, m_err, s_sel});
    end
    n_run++;
    if (m_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rd0_rdata: got %h want deadbeef", m_rdata);
    end
    tick();
    n_run++;
    if ({m_busy, m_ready, m_rdata} !== {2'b00, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL rd0_idle_hold: got %b %h want 00 deadbeef", {m_busy, m_ready}, m_rdata);
    end
  endtask

  task automatic test_write_wait();
    m_addr  = 32'h0000_7F04;
    m_wdata = 32'h1234_5678;
    m_we    = 1'b1;
    m_be    = 4'b1111;
    s_rdata = {32'hCAFE_F00D, 32'h0};
    m_req   = 1'b1;
    tick();
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_wdata = 32'h0;
    m_be    = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      n_run++;
      if ({s_sel, s_we, m_ready} !== 5'b10100) begin
        n_fail++;
        $display("FAIL wr1_access_c%0d: got %b want 10100", k, {s_sel, s_we, m_ready});
      end
      if (k == 4) s_ack = 2'b10;
      tick();
    end
    s_ack = 2'b00;
    n_run++;
    if ({s_wdata, s_be} !== {32'h1234_5678, 4'hF}) begin
      n_fail++;
      $display("FAIL wr1_latched: got %h %b want 12345678 1111", s_wdata, s_be);
    end
    n_run++;
    if ({m_ready, m_err, m_rdata} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL wr1_resp: got %b %h want 10 00000000", {m_ready, m_err}, m_rdata);
    end
    tick();
  endtask

  task automatic test_unmapped();
    m_addr = 32'h0000_5000;
    m_req  = 1'b1;
    tick();
    m_req = 1'b0;
    n_run++;
    if ({m_ready, m_err, s_sel, m_rdata} !== {4'b1100, 32'h0}) begin
      n_fail++;
      $display("FAIL unmapped_resp: got %b %h want 1100 00000000", {m_ready, m_err, s_sel},
               m_rdata);
    end
    tick();
    n_run++;
    if ({m_busy, m_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL unmapped_idle: got %b want 00", {m_busy, m_ready});
    end
  endtask

  task automatic test_decode_boundaries();
    dec_addr[0] = 32'h0000_0000; dec_sel[0] = 2'b01;
    dec_addr[1] = 32'h0000_3FFC; dec_sel[1] = 2'b01;
    dec_addr[2] = 32'h0000_4000; dec_sel[2] = 2'b00;
    dec_addr[3] = 32'h0000_7EFC; dec_sel[3] = 2'b00;
    dec_addr[4] = 32'h0000_7F00; dec_sel[4] = 2'b10;
    dec_addr[5] = 32'h0000_7FFC; dec_sel[5] = 2'b10;
    dec_addr[6] = 32'h0000_8000; dec_sel[6] = 2'b00;
    dec_addr[7] = 32'hFFFF_7F00; dec_sel[7] = 2'b00;
    m_we    = 1'b0;
    s_rdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    for (int i = 0; i < 8; i++) begin
      m_addr = dec_addr[i];
      m_req  = 1'b1;
      tick();
      m_req = 1'b0;
      n_run++;
      if ({s_sel, m_err} !== {dec_sel[i], (dec_sel[i] == 2'b00)}) begin
        n_fail++;
        $display("FAIL decode_%h: got sel %b err %b want sel %b", dec_addr[i], s_sel, m_err,
                 dec_sel[i]);
      end
      if (dec_sel[i] != 2'b00) begin
        s_ack = dec_sel[i];
        tick();
        s_ack = 2'b00;
        n_run++;
        if ({m_ready, m_err} !== 2'b10) begin
          n_fail++;
          $display("FAIL decode_resp_%h: got %b want 10", dec_addr[i], {m_ready, m_err});
        end
      end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    m_addr  = 32'h0000_7F10;
    m_we    = 1'b0;
    s_rdata = {32'hA5A5_0001, 32'h1111_1111};
    m_req   = 1'b1;
    tick();
    m_addr = 32'h0000_0020;
    s_ack  = 2'b01;
    n_run++;
    if (s_sel !== 2'b10) begin
      n_fail++;
      $display("FAIL busy_sel: got %b want 10", s_sel);
    end
    tick();
    n_run++;
    if ({m_ready, s_sel} !== 3'b010) begin
      n_fail++;
      $display("FAIL busy_stray_ack: got %b want 010", {m_ready, s_sel});
    end
    tick();
    s_ack = 2'b11;
    n_run++;
    if (m_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_stray_ack2: got %b want 0", m_ready);
    end
    tick();
    s_ack = 2'b00;
    n_run++;
    if ({m_ready, m_err, m_rdata, s_addr} !== {2'b10, 32'hA5A5_0001, 32'h0000_7F10}) begin
      n_fail++;
      $display("FAIL busy_resp: got %b %h %h want 10 a5a50001 00007f10", {m_ready, m_err},
               m_rdata, s_addr);
    end
    tick();
    n_run++;
    if ({m_busy, m_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_no_queue: got %b want 00", {m_busy, m_ready});
    end
    m_req = 1'b0;
    tick();
    n_run++;
    if ({m_busy, m_ready, s_sel} !== 4'b0000) begin
      n_fail++;
      $display("FAIL busy_single_ready: got %b want 0000", {m_busy, m_ready, s_sel});
    end
  endtask

`ifdef BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    m_addr  = 32'h0000_0100;
    m_we    = 1'b0;
    s_rdata = {32'h0, 32'h7777_7777};
    m_req   = 1'b1;
    tick();
    m_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      n_run++;
      if ({s_sel, m_ready} !== 3'b010) begin
        n_fail++;
        $display("FAIL tmo_wait_c%0d: got %b want 010", k, {s_sel, m_ready});
      end
      tick();
    end
    n_run++;
    if ({m_ready, m_err, s_sel, m_rdata} !== {4'b1100, 32'h0}) begin
      n_fail++;
      $display("FAIL tmo_resp: got %b %h want 1100 00000000", {m_ready, m_err, s_sel}, m_rdata);
    end
    tick();
    m_req = 1'b1;
    tick();
    m_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) s_ack = 2'b01;
      tick();
    end
    s_ack = 2'b00;
    n_run++;
    if ({m_ready, m_err, m_rdata} !== {2'b10, 32'h7777_7777}) begin
      n_fail++;
      $display("FAIL tmo_ack_wins: got %b %h want 10 77777777", {m_ready, m_err}, m_rdata);
    end
    tick();
  endtask
`else
  task automatic test_long_wait();
    m_addr  = 32'h0000_0100;
    m_we    = 1'b0;
    s_rdata = {32'h0, 32'h7777_7777};
    m_req   = 1'b1;
    tick();
    m_req = 1'b0;
    repeat (19) tick();
    n_run++;
    if ({m_busy, s_sel, m_ready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL long_wait_held: got %b want 1010", {m_busy, s_sel, m_ready});
    end
    s_ack = 2'b01;
    tick();
    s_ack = 2'b00;
    n_run++;
    if ({m_ready, m_err, m_rdata} !== {2'b10, 32'h7777_7777}) begin
      n_fail++;
      $display("FAIL long_wait_resp: got %b %h want 10 77777777", {m_ready, m_err}, m_rdata);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    m_addr  = 32'h0000_0040;
    m_we    = 1'b0;
    s_rdata = {32'h0, 32'h0BAD_F00D};
    m_req   = 1'b1;
    tick();
    m_req = 1'b0;
    tick();
    n_run++;
    if (s_sel !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %b want 01", s_sel);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_run++;
    if ({s_sel, m_busy, m_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b want 0000", {s_sel, m_busy, m_ready});
    end
    tick();
    n_run++;
    if ({m_ready, m_rdata} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rstmid_no_ready: got %b %h want 0 00000000", m_ready, m_rdata);
    end
    reset_n = 1'b1;
    tick();
    m_addr = 32'h0000_0044;
    m_req  = 1'b1;
    tick();
    m_req = 1'b0;
    s_ack = 2'b01;
    tick();
    s_ack = 2'b00;
    n_run++;
    if ({m_ready, m_err, m_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got %b %h want 10 0badf00d", {m_ready, m_err}, m_rdata);
    end
    tick();
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    clk     = 1'b0;
    reset_n = 1'b0;
    m_req   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    m_be    = '0;
    s_ack   = '0;
    s_rdata = '0;
    tick();
    test_reset();
    test_read_s0();
    test_write_wait();
    test_unmapped();
    test_decode_boundaries();
    test_busy_ignore();
`ifdef BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_bridge_mux.md
Name: bus_bridge_mux

Overview:
- Parametrised successor to the single-window data-memory/peripheral address splitter.
- Sits between the CPU memory stage (master) and NSLV slave ports (DM, timer, future devices).
- Registered request/acknowledge handshake with windowed address decode (base/mask per slave) and error response for unmapped addresses.
- Per-access busy tracking; slaves may stretch accesses with wait states.

Parameters:
- NSLV, 2, number of slave ports (1..8)
- DW, 32, data width; byte-enable width DW/8
- BASE, {32'h0000_7F00, 32'h0000_0000}, flat NSLV*32 base addresses, slave i at bits [32i+31:32i]
- MASK, {32'hFFFF_FF00, 32'hFFFF_C000}, flat NSLV*32 decode masks; hit(i) = ((addr & MASK_i) == BASE_i)
- TMO, 15, wait-state timeout in cycles (used only with BRIDGE_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- m_req  in  1  master request pulse, sampled only in IDLE
- m_addr  in  32  byte address
- m_wdata  in  DW  write data
- m_we  in  1  1 = write, 0 = read
- m_be  in  DW/8  byte enables
- m_busy  out  1  high whenever state != IDLE
- m_ready  out  1  one-cycle completion strobe
- m_err  out  1  valid with m_ready: unmapped or timed out
- m_rdata  out  DW  read data, valid with m_ready
- s_sel  out  NSLV  one-hot slave select, held through the access
- s_addr  out  32  latched address, broadcast to all slaves
- s_wdata  out  DW  latched write data, broadcast
- s_we  out  NSLV  per-slave write enable = latched we & s_sel[i]
- s_be  out  DW/8  latched byte enables
- s_ack  in  NSLV  per-slave completion; only the selected bit is honoured
- s_rdata  in  NSLV*DW  flat slave read data

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: state = IDLE; s_sel = 0, s_we = 0; m_ready = 0, m_err = 0, m_busy = 0; m_rdata = 0; latched addr/wdata/be = 0.
- Decode: priority encoder; the lowest index wins when windows overlap. No hit means unmapped.
- FSM states:
  - IDLE: on m_req at edge E0, latch addr/wdata/we/be. If a slave hits, store its one-hot index and go to ACCESS. If no slave hits, go to ERR. No req: stay in IDLE.
  - ACCESS: s_sel[idx] = 1 and s_we[idx] = we from the cycle after E0. When s_ack[idx] is sampled high, capture the read data (or keep 0 for writes), drop s_sel, go to RESP.
  - RESP: m_ready = 1 for exactly one cycle; m_err = 0 (timeout path: 1); m_rdata holds captured data. Then go to IDLE.
  - ERR: m_ready = 1, m_err = 1, m_rdata = 0 for one cycle; then go to IDLE. No s_sel is ever asserted.
- Latency:
  - Zero-wait slave (ack in first ACCESS cycle): m_ready is high 2 cycles after the req edge.
  - Each extra ack-delay cycle adds 1.
  - Unmapped access: m_ready is high 1 cycle after the req edge.
- m_req while busy (ACCESS/RESP/ERR) is ignored, not queued. The master must wait for m_busy = 0.
- m_req in the RESP cycle is also ignored; the earliest next accept is the cycle after m_ready.
- s_ack bits from unselected slaves are ignored.
- Simultaneous ack of the selected slave and any other bit: only the selected bit counts.
- m_rdata keeps its value until the next completion. Write completions load 0.
- Reset asserted mid-access: immediate return to IDLE, s_sel cleared, no m_ready produced.

Optional Feature:
- Macro BRIDGE_TIMEOUT_EN.
- Defined: a $clog2(TMO+1)-bit counter clears on ACCESS entry and increments each ACCESS cycle without ack. At count == TMO with no ack, s_sel drops and the FSM goes to RESP with m_err = 1 and m_rdata = 0. If ack arrives in the same cycle as the timeout, ack wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely for ack.

Test Plan:
- Read slave 0, ack on the first ACCESS cycle: m_addr = 0x0000_0010, s_rdata0 = 0xDEAD_BEEF -> s_sel = 01 one cycle after req; m_ready = 1, m_err = 0, m_rdata = 0xDEAD_BEEF at req+2.
- Write slave 1 with 3 wait cycles: m_addr = 0x0000_7F04, m_wdata = 0x1234_5678, m_be = 4'b1111 -> s_we = 10 held 4 cycles; s_wdata = 0x1234_5678; m_ready at req+5; m_rdata = 0.
- Unmapped address 0x0000_5000 -> no s_sel; m_ready = 1, m_err = 1, m_rdata = 0 at req+1.
- Second m_req asserted while busy, plus stray s_ack[0] during a slave 1 access -> second request not accepted, stray ack has no effect; a single m_ready results.
- BRIDGE_TIMEOUT_EN, TMO = 15, slave never acks -> s_sel drops after 15 ACCESS cycles; m_ready = 1, m_err = 1. Repeat with ack exactly on cycle 15 -> m_err = 0.
- reset_n pulsed low during ACCESS -> s_sel = 0 and m_busy = 0 immediately, no m_ready. A fresh read afterwards completes normally.
